// File: rtl/grf_pkg.sv
// Shared constants and the write-port priority helper for the multi-port register file.
package grf_pkg;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int ZERO_IDX  = 0;
  localparam int MAX_WRITE = 4;
  localparam int MAX_AW    = 16;

  // Highest-index effective write port hitting addr, or nw when none matches.
  function automatic logic [2:0] win_port(
    input logic [MAX_WRITE-1:0]        we,
    input logic [MAX_WRITE*MAX_AW-1:0] wa,
    input logic [MAX_AW-1:0]           addr,
    input int                          nw,
    input bit                          zero_reg
  );
    logic [2:0] win;
    win = 3'(nw);
    for (int j = 0; j < MAX_WRITE; j++) begin
      if (j < nw && we[j] && wa[j*MAX_AW +: MAX_AW] == addr &&
          !(zero_reg && addr == MAX_AW'(ZERO_IDX)))
        win = 3'(j);
    end
    return win;
  endfunction
endpackage

// File: rtl/grf_wsel.sv
// Combinational write-port selector: resolves which write port (if any) targets one address.
module grf_wsel
  import grf_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic [NUM_WRITE-1:0]    we,
  input  logic [NUM_WRITE*AW-1:0] wa,
  input  logic [NUM_WRITE*DW-1:0] wd,
  input  logic [AW-1:0]           addr,
  output logic                    hit,
  output logic [DW-1:0]           data,
  output logic [2:0]              idx
);
  logic [MAX_WRITE-1:0]        we_ext;
  logic [MAX_WRITE*MAX_AW-1:0] wa_ext;

  always_comb begin
    we_ext = '0;
    wa_ext = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      we_ext[j]                   = we[j];
      wa_ext[j*MAX_AW +: MAX_AW]  = MAX_AW'(wa[j*AW +: AW]);
    end
    idx  = win_port(we_ext, wa_ext, MAX_AW'(addr), NUM_WRITE, ZERO_REG != 0);
    hit  = (idx != 3'(NUM_WRITE));
    data = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (idx == 3'(j)) data = wd[j*DW +: DW];
    end
  end
endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with same-cycle write bypass and a pending-write scoreboard.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [NUM_READ*AW-1:0]  RA,
  output logic [NUM_READ*DW-1:0]  RD,
  output logic [NUM_READ-1:0]     RBUSY,
  input  logic [NUM_WRITE-1:0]    WE,
  input  logic [NUM_WRITE*AW-1:0] WA,
  input  logic [NUM_WRITE*DW-1:0] WD,
  input  logic                    ISSUE_EN,
  input  logic [AW-1:0]           ISSUE_A
);
  localparam int NREG = 2**AW;

  if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_nr
    $error("grf_mp: NUM_READ must be in 1..8");
  end
  if (NUM_WRITE < 1 || NUM_WRITE > MAX_WRITE) begin : g_bad_nw
    $error("grf_mp: NUM_WRITE must be in 1..4");
  end
  if (AW < 1 || AW > MAX_AW) begin : g_bad_aw
    $error("grf_mp: AW out of supported range");
  end

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic [NREG-1:0] wr_hit;
  logic [DW-1:0]   wr_data [NREG];
  logic [2:0]      wr_idx  [NREG];

  logic [NUM_READ-1:0] rd_hit;
  logic [DW-1:0]       rd_data [NUM_READ];
  logic [2:0]          rd_idx  [NUM_READ];
  logic                idx_unused;
  logic                issue_ok;

  for (genvar r = 0; r < NREG; r++) begin : g_wr
    grf_wsel #(.DW(DW), .AW(AW), .NUM_WRITE(NUM_WRITE), .ZERO_REG(ZERO_REG)) u_sel (
      .we(WE), .wa(WA), .wd(WD), .addr(AW'(r)),
      .hit(wr_hit[r]), .data(wr_data[r]), .idx(wr_idx[r])
    );
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    assign a       = RA[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (a == AW'(ZERO_IDX));

    grf_wsel #(.DW(DW), .AW(AW), .NUM_WRITE(NUM_WRITE), .ZERO_REG(ZERO_REG)) u_sel (
      .we(WE), .wa(WA), .wd(WD), .addr(a),
      .hit(rd_hit[k]), .data(rd_data[k]), .idx(rd_idx[k])
    );

    // Forwarded write data wins over storage; a forwarded register is never busy.
    assign RD[k*DW +: DW] = rd_hit[k] ? rd_data[k] : (is_zero ? '0 : regs_q[a]);
    assign RBUSY[k]       = pend_q[a] && !rd_hit[k] && !is_zero;
  end

  always_comb begin
    idx_unused = 1'b0;
    for (int r = 0; r < NREG; r++)     idx_unused = idx_unused ^ (^wr_idx[r]);
    for (int k = 0; k < NUM_READ; k++) idx_unused = idx_unused ^ (^rd_idx[k]);
  end

  assign issue_ok = ISSUE_EN && !((ZERO_REG != 0) && (ISSUE_A == AW'(ZERO_IDX)));

  // A new issue supersedes a same-cycle writeback of the previous producer.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int r = 0; r < NREG; r++) begin
      if (wr_hit[r]) begin
        regs_d[r] = wr_data[r];
        pend_d[r] = 1'b0;
      end
    end
    if (issue_ok) pend_d[ISSUE_A] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_grf_mp.sv
// Directed plus randomized bench for grf_mp against an array-based reference model.
module tb_grf_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int ZR = 1;
  localparam int NREG = 2**AW;

  logic              clk;
  logic              RESET;
  logic [NR*AW-1:0]  RA;
  logic [NR*DW-1:0]  RD;
  logic [NR-1:0]     RBUSY;
  logic [NW-1:0]     WE;
  logic [NW*AW-1:0]  WA;
  logic [NW*DW-1:0]  WD;
  logic              ISSUE_EN;
  logic [AW-1:0]     ISSUE_A;

  logic [DW-1:0] m_reg  [NREG];
  bit            m_pend [NREG];
  int n_tests = 0;
  int n_fail  = 0;

  grf_mp #(.DW(DW), .AW(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(ZR)) dut (
    .clk(clk), .RESET(RESET), .RA(RA), .RD(RD), .RBUSY(RBUSY),
    .WE(WE), .WA(WA), .WD(WD), .ISSUE_EN(ISSUE_EN), .ISSUE_A(ISSUE_A)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit eff(int j);
    return WE[j] && !(ZR != 0 && WA[j*AW +: AW] == 0);
  endfunction

  function automatic logic [DW-1:0] m_rd(int k);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = RA[k*AW +: AW];
    v = (ZR != 0 && a == 0) ? '0 : m_reg[a];
    for (int j = 0; j < NW; j++)
      if (eff(j) && WA[j*AW +: AW] == a) v = WD[j*DW +: DW];
    return v;
  endfunction

  function automatic logic m_busy(int k);
    logic [AW-1:0] a;
    a = RA[k*AW +: AW];
    if (ZR != 0 && a == 0) return 1'b0;
    for (int j = 0; j < NW; j++)
      if (eff(j) && WA[j*AW +: AW] == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_update();
    if (RESET) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r]  = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (eff(j)) begin
          m_reg[WA[j*AW +: AW]]  = WD[j*DW +: DW];
          m_pend[WA[j*AW +: AW]] = 1'b0;
        end
      end
      if (ISSUE_EN && !(ZR != 0 && ISSUE_A == 0)) m_pend[ISSUE_A] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic expect_rd(int k, logic [DW-1:0] v, string tag);
    n_tests++;
    assert (RD[k*DW +: DW] === v) else begin
      n_fail++;
      $error("FAIL %s rd%0d: got %h expected %h", tag, k, RD[k*DW +: DW], v);
    end
  endtask

  task automatic expect_busy(int k, logic v, string tag);
    n_tests++;
    assert (RBUSY[k] === v) else begin
      n_fail++;
      $error("FAIL %s busy%0d: got %b expected %b", tag, k, RBUSY[k], v);
    end
  endtask

  task automatic check_model(string tag);
    for (int k = 0; k < NR; k++) begin
      expect_rd(k, m_rd(k), tag);
      expect_busy(k, m_busy(k), tag);
    end
  endtask

  task automatic idle();
    RESET = 1'b0; WE = '0; WA = '0; WD = '0; ISSUE_EN = 1'b0; ISSUE_A = '0;
  endtask

  initial begin
    idle();
    RA = '0;
    RESET = 1'b1;
    tick();
    tick();
    idle();

    // Reset state: every register and pending bit cleared.
    for (int r = 0; r < NREG; r += 2) begin
      RA[0 +: AW] = AW'(r); RA[AW +: AW] = AW'(r + 1);
      settle();
      expect_rd(0, '0, "reset_rd"); expect_rd(1, '0, "reset_rd");
      expect_busy(0, 1'b0, "reset_busy"); expect_busy(1, 1'b0, "reset_busy");
      tick();
    end

    // Random writes and issues, then reset with a write to r3 in the reset cycle.
    for (int i = 0; i < 8; i++) begin
      WE = '1; WA[0 +: AW] = AW'($urandom_range(1, 31)); WA[AW +: AW] = AW'($urandom_range(1, 31));
      WD = {$urandom, $urandom}; ISSUE_EN = 1'b1; ISSUE_A = AW'($urandom_range(1, 31));
      tick();
    end
    WE = 2'b01; WA[0 +: AW] = 5'd3; WD[0 +: DW] = 32'hABCD; ISSUE_EN = 1'b1; ISSUE_A = 5'd3;
    tick();
    RESET = 1'b1; WE = 2'b01; WA[0 +: AW] = 5'd3; WD[0 +: DW] = 32'h1234; ISSUE_EN = 1'b1; ISSUE_A = 5'd3;
    tick();
    idle();
    RA[0 +: AW] = 5'd3; RA[AW +: AW] = 5'd17;
    settle();
    expect_rd(0, '0, "rst_drop_wr"); expect_busy(0, 1'b0, "rst_drop_iss");
    expect_rd(1, '0, "rst_r17"); expect_busy(1, 1'b0, "rst_r17_busy");
    tick();

    // Write with same-cycle bypass, then stored value.
    WE = 2'b01; WA[0 +: AW] = 5'd5; WD[0 +: DW] = 32'hDEADBEEF; RA[0 +: AW] = 5'd5;
    settle();
    expect_rd(0, 32'hDEADBEEF, "bypass");
    tick();
    idle();
    settle();
    expect_rd(0, 32'hDEADBEEF, "stored");
    tick();

    // Write-port priority on the same register.
    WE = 2'b11; WA[0 +: AW] = 5'd7; WA[AW +: AW] = 5'd7;
    WD[0 +: DW] = 32'h11; WD[DW +: DW] = 32'h22; RA[AW +: AW] = 5'd7;
    settle();
    expect_rd(1, 32'h22, "prio_bypass");
    tick();
    idle();
    settle();
    expect_rd(1, 32'h22, "prio_stored");
    tick();

    // Zero register ignores writes and issues.
    WE = 2'b01; WA[0 +: AW] = 5'd0; WD[0 +: DW] = 32'hFFFFFFFF;
    ISSUE_EN = 1'b1; ISSUE_A = 5'd0; RA = '0;
    settle();
    expect_rd(0, '0, "zero_now"); expect_rd(1, '0, "zero_now");
    expect_busy(0, 1'b0, "zero_now"); expect_busy(1, 1'b0, "zero_now");
    tick();
    idle();
    settle();
    expect_rd(0, '0, "zero_next"); expect_rd(1, '0, "zero_next");
    expect_busy(0, 1'b0, "zero_next"); expect_busy(1, 1'b0, "zero_next");
    tick();

    // Scoreboard: issue at t, busy from t+1, cleared by writeback at t+3.
    ISSUE_EN = 1'b1; ISSUE_A = 5'd9; RA[0 +: AW] = 5'd9;
    settle();
    expect_busy(0, 1'b0, "sb_t");
    tick();
    idle();
    settle();
    expect_busy(0, 1'b1, "sb_t1");
    tick();
    settle();
    expect_busy(0, 1'b1, "sb_t2");
    tick();
    WE = 2'b01; WA[0 +: AW] = 5'd9; WD[0 +: DW] = 32'h55;
    settle();
    expect_busy(0, 1'b0, "sb_t3_busy"); expect_rd(0, 32'h55, "sb_t3_rd");
    tick();
    idle();
    settle();
    expect_busy(0, 1'b0, "sb_t4_busy"); expect_rd(0, 32'h55, "sb_t4_rd");
    tick();

    // Set/clear collision: the new issue wins.
    ISSUE_EN = 1'b1; ISSUE_A = 5'd4;
    tick();
    ISSUE_EN = 1'b1; ISSUE_A = 5'd4; WE = 2'b10; WA[AW +: AW] = 5'd4; WD[DW +: DW] = 32'h99;
    RA[0 +: AW] = 5'd4; RA[AW +: AW] = 5'd4;
    settle();
    expect_rd(0, 32'h99, "coll_rd"); expect_busy(0, 1'b0, "coll_busy");
    expect_rd(1, 32'h99, "coll_rd"); expect_busy(1, 1'b0, "coll_busy");
    tick();
    idle();
    settle();
    expect_rd(0, 32'h99, "coll_next_rd"); expect_busy(0, 1'b1, "coll_next_busy");
    tick();

    // Randomized traffic, narrow address range half the time to force collisions.
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 1) == 1);
      RESET    = ($urandom_range(0, 39) == 0);
      WE       = NW'($urandom);
      WD       = {$urandom, $urandom};
      ISSUE_EN = ($urandom_range(0, 2) == 0);
      ISSUE_A  = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      for (int j = 0; j < NW; j++)
        WA[j*AW +: AW] = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      for (int k = 0; k < NR; k++)
        RA[k*AW +: AW] = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      settle();
      check_model("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised successor of the pipeline general register file.
- Provides configurable data width, register count, read-port count and write-port count.
- Performs same-cycle write-to-read bypass on every read port, with deterministic write-port priority.
- Adds a pending-write scoreboard: the decode stage marks a destination as pending, and a writeback to that register clears the mark. Hazard logic uses the per-read-port busy flags to stall.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; register count is 2**AW.
- NUM_READ, 2, number of read ports (1..8).
- NUM_WRITE, 2, number of write ports (1..4); a higher index has higher priority.
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and issues.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RA  in  NUM_READ*AW  read addresses; port k occupies bits [k*AW +: AW].
- RD  out  NUM_READ*DW  read data; port k occupies bits [k*DW +: DW].
- RBUSY  out  NUM_READ  port k's register has an outstanding producer.
- WE  in  NUM_WRITE  write enables.
- WA  in  NUM_WRITE*AW  write addresses.
- WD  in  NUM_WRITE*DW  write data.
- ISSUE_EN  in  1  mark a destination register as pending.
- ISSUE_A  in  AW  destination register to mark.

Behaviour:
- Clock and reset: one clock, clk. RESET is synchronous and active-high, sampled on the rising edge of clk.
- Reset: on a rising edge with RESET=1, all registers become 0 and all pending bits become 0. RESET overrides WE and ISSUE_EN in the same cycle.
- Reset mid-operation: writes and issues presented in a reset cycle are dropped.
- Output values: RD and RBUSY are combinational. After reset, every RD reads 0 and every RBUSY reads 0.
- Effective write: port j is effective when WE[j]=1 and not (ZERO_REG=1 and WA[j]=0).
- Write commit: each effective write updates its register on the rising edge (latency 1).
- Write conflict: if several effective ports target the same register, the highest-index port's data is stored.
- Read, base value: RD[k] is the stored value of RA[k], or 0 when ZERO_REG=1 and RA[k]=0.
- Read, bypass: if any effective write matches RA[k] this cycle, RD[k] equals WD of the highest-index matching port. Bypass never applies to register 0 when ZERO_REG=1.
- Read-port independence: all read ports are independent; duplicate addresses across ports are legal.
- Pending set: ISSUE_EN=1 sets pending[ISSUE_A] on the edge. It is ignored for address 0 when ZERO_REG=1.
- Pending clear: any effective write clears pending[WA[j]] on the edge.
- Pending conflict: a set and a clear of the same address in the same cycle leaves pending=1, because the new producer supersedes the old one.
- RBUSY: RBUSY[k] = pending[RA[k]] AND no effective write matches RA[k] this cycle. The value being written is forwarded, so the reader does not stall.
- RBUSY for register 0: always 0 when ZERO_REG=1.
- Edge cases:
  - ISSUE_EN to an already-pending register leaves it pending; no counter is kept.
  - A write to a non-pending register is a normal write and leaves pending=0.
- Timing: no combinational path from ISSUE_EN/ISSUE_A to RBUSY. A same-cycle issue is visible from the next cycle.
- Parameter checks: elaboration-time checks for the NUM_READ and NUM_WRITE ranges.

Decomposition:
- Shared package, grf_pkg:
  - Default DW/AW constants.
  - The zero-register index constant.
  - A helper function returning the winning write-port index for an address; it returns the "none" encoding NUM_WRITE when no port matches.
- Sub-module grf_wsel (combinational):
  - Given WE/WA/WD and one address, produces hit, data and winning index.
  - Instantiated once per read port and once for each storage entry's update decision, or replaced by a per-register priority loop.
- Storage and the pending vector stay in grf_mp.

Test Plan:
- Reset: RESET=1 for one edge after random writes -> all RD=0 and all RBUSY=0. Writing WE0=1, WA0=3, WD0=0x1234 during reset -> r3 still reads 0 afterwards.
- Write and bypass: WE0=1, WA0=5, WD0=0xDEADBEEF with RA port0=5 in the same cycle -> RD0=0xDEADBEEF combinationally. Next cycle with WE=0 -> RD0 still reads 0xDEADBEEF.
- Priority: WE0 and WE1 both write r7 with 0x11 and 0x22, RA port1=7 -> same-cycle RD1=0x22; after the edge, r7=0x22.
- Zero register: a write of 0xFFFFFFFF to r0 plus ISSUE_A=0 -> RD=0 and RBUSY=0 on all ports, in the same and the next cycle.
- Scoreboard: issue r9 at cycle t, RA port0=9.
  - Cycle t -> RBUSY0=0.
  - Cycle t+1 -> RBUSY0=1.
  - Write r9=0x55 at cycle t+3 -> RBUSY0=0 and RD0=0x55 in that cycle; pending is clear from t+4.
- Set/clear collision: with r4 pending, ISSUE_A=4 and WE1 writing r4=0x99 in the same cycle -> RD reads 0x99 and RBUSY=0 that cycle. From the next cycle RBUSY=1 and r4 holds 0x99.
